// File: rtl/dffram_arbiter.sv
// dffram_arbiter: shares one single-port 256x32 DFFRAM between an instruction
// fetch port (read-only) and a data port (byte-masked read/write).
// At most one RAM access per cycle. Round-robin priority resolves conflicts.
// Each grant produces a one-cycle response pulse on the following cycle.
//
// Ports
//   CLK, RSTn            clock, asynchronous active-low reset
//   i_req/i_addr         instruction request (held until i_gnt)
//   i_gnt                instruction grant, combinational
//   i_rvalid/i_rdata     instruction response, one cycle after grant
//   d_req/d_addr/d_we/d_wdata  data request (held until d_gnt)
//   d_gnt                data grant, combinational
//   d_rvalid/d_rdata     data response or write ack, one cycle after grant
//   ram_EN/WE/A/Di/Do    RAM macro port (Do valid the cycle after access)
//   conflict_cnt         saturating count of cycles with both requests high
module dffram_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          CLK,
  input  logic          RSTn,

  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,

  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [3:0]    d_we,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,

  output logic          ram_EN,
  output logic [3:0]    ram_WE,
  output logic [AW-1:0] ram_A,
  output logic [31:0]   ram_Di,
  input  logic [31:0]   ram_Do,

  output logic [CW-1:0] conflict_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  // Which port wins the next conflict.
  typedef enum logic {
    PRIO_I = 1'b0,
    PRIO_D = 1'b1
  } prio_t;

  // Port tag of the outstanding response.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  prio_t         prio_q,       prio_d;
  port_t         resp_port_q,  resp_port_d;
  logic          resp_valid_q, resp_valid_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic          both_req;

  // State registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      prio_q       <= PRIO_I;
      resp_port_q  <= PORT_I;
      resp_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      prio_q       <= prio_d;
      resp_port_q  <= resp_port_d;
      resp_valid_q <= resp_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  // Grant selection, RAM drive and next-state.
  always_comb begin
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    ram_EN       = 1'b0;
    ram_WE       = 4'b0000;
    ram_A        = '0;
    ram_Di       = '0;
    prio_d       = prio_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_port_d  = resp_port_q;
    both_req     = i_req & d_req;

    // Grants are held off while reset is asserted.
    if (RSTn) begin
      if (both_req) begin
        if (prio_q == PRIO_I) begin
          i_gnt  = 1'b1;
          prio_d = PRIO_D;
        end else begin
          d_gnt  = 1'b1;
          prio_d = PRIO_I;
        end
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (i_req) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end

    // Di follows d_wdata whenever the RAM is enabled; WE gates it for I reads.
    if (i_gnt) begin
      ram_EN = 1'b1;
      ram_A  = i_addr;
      ram_Di = d_wdata;
    end else if (d_gnt) begin
      ram_EN = 1'b1;
      ram_A  = d_addr;
      ram_WE = d_we;
      ram_Di = d_wdata;
    end

    if (i_gnt || d_gnt) begin
      resp_valid_d = 1'b1;
      resp_port_d  = d_gnt ? PORT_D : PORT_I;
    end
  end

  // Response steering: RAM output is only forwarded to the port that owns it.
  assign i_rvalid     = resp_valid_q && (resp_port_q == PORT_I);
  assign d_rvalid     = resp_valid_q && (resp_port_q == PORT_D);
  assign i_rdata      = i_rvalid ? ram_Do : 32'h0;
  assign d_rdata      = d_rvalid ? ram_Do : 32'h0;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dffram_arbiter.sv
module tb_dffram_arbiter;

  localparam int unsigned AW = 8;

  logic          CLK;
  logic          RSTn;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_we;
  logic [31:0]   d_wdata;

  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, ram_EN;
  logic [31:0]   i_rdata, d_rdata, ram_Di, ram_Do;
  logic [3:0]    ram_WE;
  logic [AW-1:0] ram_A;
  logic [15:0]   conflict_cnt;

  logic          s_i_gnt, s_i_rvalid, s_d_gnt, s_d_rvalid, s_ram_EN;
  logic [31:0]   s_i_rdata, s_d_rdata, s_ram_Di;
  logic [3:0]    s_ram_WE;
  logic [AW-1:0] s_ram_A;
  logic [3:0]    s_conflict_cnt;

  int checks = 0;
  int errors = 0;

  dffram_arbiter #(.AW(AW), .CW(16)) u_dut (
    .CLK(CLK), .RSTn(RSTn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di), .ram_Do(ram_Do),
    .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance for saturation; it sees the same requests and RAM data.
  dffram_arbiter #(.AW(AW), .CW(4)) u_sat (
    .CLK(CLK), .RSTn(RSTn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(s_i_gnt), .i_rvalid(s_i_rvalid), .i_rdata(s_i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
    .ram_EN(s_ram_EN), .ram_WE(s_ram_WE), .ram_A(s_ram_A), .ram_Di(s_ram_Di), .ram_Do(ram_Do),
    .conflict_cnt(s_conflict_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single-port RAM: read-before-write, output registered.
  logic [31:0] ram_mem [256];
  always @(posedge CLK) begin
    if (ram_EN) begin
      ram_Do <= ram_mem[ram_A];
      for (int b = 0; b < 4; b++)
        if (ram_WE[b]) ram_mem[ram_A][8*b +: 8] <= ram_Di[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] m_mem   [256];
  bit          m_known [256];
  int          m_conf;
  bit          m_rv, m_rd, m_rknown;
  logic [31:0] m_rdata;

  // Compare process: checks every cycle just before the rising edge, then
  // advances the model as that edge will.
  initial begin : compare
    bit          e_i, e_d, e_en, i_wins;
    logic [3:0]  e_we;
    logic [AW-1:0] e_a;
    logic [31:0] e_di, e_ird, e_drd;
    m_conf = 0; m_rv = 0; m_rd = 0; m_rknown = 0; m_rdata = '0;
    forever begin
      @(negedge CLK);
      #3;
      if (!RSTn) begin
        m_conf = 0; m_rv = 0; m_rd = 0;
      end
      // The k-th conflict since reset (k from 0) goes to I when k is even.
      i_wins = (m_conf % 2) == 0;
      e_i  = RSTn && i_req && (!d_req || i_wins);
      e_d  = RSTn && d_req && (!i_req || !i_wins);
      e_en = e_i || e_d;
      e_a  = e_i ? i_addr : (e_d ? d_addr : '0);
      e_we = e_d ? d_we : 4'b0000;
      e_di = e_en ? d_wdata : 32'h0;

      chk("i_gnt", 32'(i_gnt), 32'(e_i));
      chk("d_gnt", 32'(d_gnt), 32'(e_d));
      chk("ram_EN", 32'(ram_EN), 32'(e_en));
      chk("ram_A", 32'(ram_A), 32'(e_a));
      chk("ram_WE", 32'(ram_WE), 32'(e_we));
      chk("ram_Di", 32'(ram_Di), e_di);
      chk("i_rvalid", 32'(i_rvalid), 32'(m_rv && !m_rd));
      chk("d_rvalid", 32'(d_rvalid), 32'(m_rv && m_rd));
      e_ird = (m_rv && !m_rd) ? m_rdata : 32'h0;
      e_drd = (m_rv && m_rd) ? m_rdata : 32'h0;
      if (!(m_rv && !m_rknown)) begin
        chk("i_rdata", i_rdata, e_ird);
        chk("d_rdata", d_rdata, e_drd);
      end
      chk("conflict_cnt", 32'(conflict_cnt), (m_conf > 65535) ? 32'd65535 : 32'(m_conf));
      chk("sat_cnt", 32'(s_conflict_cnt), (m_conf > 15) ? 32'd15 : 32'(m_conf));
      chk("sat_gnt", {30'h0, s_i_gnt, s_d_gnt}, {30'h0, e_i, e_d});
      chk("sat_ram", {s_ram_Di[26:0], s_ram_EN, s_ram_WE}, {e_di[26:0], e_en, e_we});
      chk("sat_ramA", 32'(s_ram_A), 32'(e_a));
      chk("sat_rsp", {s_i_rdata ^ s_d_rdata} | 32'(s_i_rvalid) | (32'(s_d_rvalid) << 1),
                     {i_rdata ^ d_rdata} | 32'(m_rv && !m_rd) | (32'(m_rv && m_rd) << 1));

      if (RSTn) begin
        m_rv = e_en;
        m_rd = e_d;
        if (e_en) begin
          m_rknown = m_known[e_a];
          m_rdata  = m_mem[e_a];
          if (e_d && d_we != 4'b0000) begin
            for (int b = 0; b < 4; b++)
              if (d_we[b]) m_mem[e_a][8*b +: 8] = d_wdata[8*b +: 8];
            if (d_we == 4'hF) m_known[e_a] = 1'b1;
          end
        end
        if (i_req && d_req) m_conf++;
      end
    end
  end

  task automatic idle_all();
    i_req = 1'b0; d_req = 1'b0; d_we = 4'b0000;
  endtask

  // Stimulus.
  initial begin : driver
    bit ig, dg;
    RSTn = 1'b0; i_req = 1'b1; d_req = 1'b1;
    i_addr = '0; d_addr = '0; d_we = 4'b0000; d_wdata = '0;

    // Reset: grants forced low, responses and counter cleared.
    repeat (3) begin
      @(negedge CLK); #4;
      chk("rst_i_gnt", 32'(i_gnt), 32'd0);
      chk("rst_ram_EN", 32'(ram_EN), 32'd0);
      chk("rst_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'd0);
      chk("rst_cnt", 32'(conflict_cnt), 32'd0);
    end
    @(negedge CLK); RSTn = 1'b1; idle_all();

    // Fill every word via back-to-back data writes.
    for (int a = 0; a < 256; a++) begin
      @(negedge CLK);
      d_req = 1'b1; d_addr = AW'(a); d_we = 4'hF;
      d_wdata = (a == 16) ? 32'hDEADBEEF : (a == 32) ? 32'h11223344 : $urandom;
    end

    // Single-port traffic leaves priority at I.
    @(negedge CLK);
    i_req = 1'b1; i_addr = '0; d_req = 1'b1; d_addr = '0; d_we = 4'b0000;
    #4 chk("prio_kept", {30'h0, i_gnt, d_gnt}, 32'b10);
    @(negedge CLK); i_req = 1'b0;
    @(negedge CLK); idle_all();

    // Single instruction read.
    @(negedge CLK); i_req = 1'b1; i_addr = 8'h10;
    #4 chk("iread_gnt", {29'h0, i_gnt, ram_EN, |ram_WE}, 32'b110);
    @(negedge CLK); i_req = 1'b0;
    #4 chk("iread_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'b10);
    chk("iread_rdata", i_rdata, 32'hDEADBEEF);

    // Byte write returns pre-write contents, then read back the merged word.
    @(negedge CLK); d_req = 1'b1; d_addr = 8'h20; d_we = 4'b0101; d_wdata = 32'hAABBCCDD;
    #4 chk("bw_gnt", 32'(d_gnt), 32'd1);
    @(negedge CLK); d_we = 4'b0000;
    #4 chk("bw_ack", 32'(d_rvalid), 32'd1);
    chk("bw_old", d_rdata, 32'h11223344);
    @(negedge CLK); idle_all();
    #4 chk("bw_new", d_rdata, 32'h11BB33DD);

    // Continuous contention after reset alternates I, D, I, D...
    @(negedge CLK); RSTn = 1'b0;
    @(negedge CLK); RSTn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK); i_req = 1'b1; d_req = 1'b1; i_addr = 8'h01; d_addr = 8'h02;
      #4 chk("alt_gnt", {30'h0, i_gnt, d_gnt}, (k % 2 == 0) ? 32'b10 : 32'b01);
    end
    @(negedge CLK); idle_all();
    #4 chk("alt_cnt", 32'(conflict_cnt), 32'd6);
    chk("alt_last_rsp", {30'h0, i_rvalid, d_rvalid}, 32'b01);

    // Back-to-back data reads of words 0..3.
    for (int a = 0; a < 4; a++) begin
      @(negedge CLK); d_req = 1'b1; d_addr = AW'(a); d_we = 4'b0000;
    end
    @(negedge CLK); idle_all();

    // Reset right after a grant drops the pending response.
    @(negedge CLK); i_req = 1'b1; i_addr = 8'h10;
    #4 chk("mid_gnt", 32'(i_gnt), 32'd1);
    @(negedge CLK); i_req = 1'b0; RSTn = 1'b0;
    #4 chk("mid_rvalid", 32'(i_rvalid), 32'd0);
    chk("mid_cnt", 32'(conflict_cnt), 32'd0);
    @(negedge CLK); RSTn = 1'b1; i_req = 1'b1; d_req = 1'b1;
    #4 chk("mid_first", {30'h0, i_gnt, d_gnt}, 32'b10);

    // Hold contention for 20 cycles in total: narrow counter stops at 15.
    repeat (19) @(negedge CLK);
    @(negedge CLK); idle_all();
    #4 chk("sat15", 32'(s_conflict_cnt), 32'd15);
    chk("cnt20", 32'(conflict_cnt), 32'd20);

    // Randomized traffic with occasional reset pulses.
    ig = 1'b1; dg = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      RSTn = ($urandom_range(99) != 0);
      if (!i_req || ig) begin
        i_req  = ($urandom_range(2) != 0);
        i_addr = AW'($urandom);
      end
      if (!d_req || dg) begin
        d_req   = ($urandom_range(2) != 0);
        d_addr  = AW'($urandom_range(15));
        d_we    = ($urandom_range(1) != 0) ? 4'($urandom) : 4'b0000;
        d_wdata = $urandom;
      end
      #4;
      ig = i_gnt;
      dg = d_gnt;
    end

    @(negedge CLK); RSTn = 1'b1; idle_all();
    @(negedge CLK);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dffram_arbiter.md
# dffram_arbiter

Two-requester arbiter sharing one single-port 256x32 DFFRAM between the core's instruction-fetch port (read-only) and data port (byte-masked read/write). It sits between the core's memory interfaces and the RAM macro. It issues at most one RAM access per cycle, uses round-robin priority on conflicts, and returns read data with a one-cycle response pulse. It also keeps a saturating contention counter for performance debug.

## Interface
- AW, 8: RAM word-address width (256 words).
- CW, 16: contention counter width.
- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  asynchronous active-low reset.
- i_req  in  1  instruction port request; held with i_addr until granted.
- i_addr  in  AW  instruction word address.
- i_gnt  out  1  instruction request accepted this cycle (combinational).
- i_rvalid  out  1  instruction read data valid (registered pulse).
- i_rdata  out  32  instruction read data; 0 when i_rvalid=0.
- d_req  in  1  data port request; held with d_addr/d_we/d_wdata until granted.
- d_addr  in  AW  data word address.
- d_we  in  4  byte write enables; 4'b0000 = read.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  data response (read data or write ack), registered pulse.
- d_rdata  out  32  data read data; 0 when d_rvalid=0.
- ram_EN  out  1  RAM enable.
- ram_WE  out  4  RAM byte write enables.
- ram_A  out  AW  RAM address.
- ram_Di  out  32  RAM write data.
- ram_Do  in  32  RAM read data, valid the cycle after the access.
- conflict_cnt  out  CW  count of cycles with both requests asserted, saturating.

## Operation
- State: prio (0 = I preferred, 1 = D preferred), resp_port (1 bit), resp_valid (1 bit), conflict_cnt.
- Grant (combinational, same cycle):
  - Only i_req: i_gnt=1.
  - Only d_req: d_gnt=1.
  - Both: grant the preferred port, then set prio to point at the other port.
  - Single-requester grants leave prio unchanged.
- RAM drive:
  - ram_EN = i_gnt | d_gnt.
  - ram_A = address of the granted port.
  - ram_WE = d_we when d_gnt, else 4'b0000. The I port never writes.
  - ram_Di = d_wdata.
  - With no grant: ram_EN=0, ram_WE=0, ram_A=0, ram_Di=0.
- Response:
  - On a grant, resp_valid<=1 and resp_port<=granted port; otherwise resp_valid<=0.
  - Next cycle: matching rvalid=1 and rdata=ram_Do; the other port's rvalid=0 and rdata=0.
- Data write: d_rvalid still pulses as an ack. d_rdata then carries the word's pre-write contents, because the RAM reads before it writes.
- conflict_cnt increments by 1 on each cycle with i_req & d_req. It holds at 2^CW-1.
- Requesters must keep req, addr, we and wdata stable until gnt. They may drop req or change the request the cycle after gnt.

## Timing
- Reset (RSTn=0, asynchronous): prio=0, resp_valid=0, resp_port=0, conflict_cnt=0.
  - Hence i_rvalid=d_rvalid=0 and i_rdata=d_rdata=0.
  - gnt and ram_* outputs follow the combinational rules and are 0 when there is no request.
  - While RSTn=0, grants are forced low and ram_EN=0.
- Latency:
  - Request to gnt: 0 cycles.
  - gnt to rvalid: exactly 1 cycle.
- Throughput: one access per cycle. Back-to-back grants to the same port give back-to-back rvalid pulses.
- Under continuous contention the grants alternate I, D, I, D... No port waits more than 1 cycle.
- Reset asserted in the cycle after a grant: the pending response is dropped and rvalid stays 0. A write already clocked into the RAM is not undone. RAM contents are never reset.
- Release after reset: the first conflict is granted to I.

## Test plan
- Single I read: preload mem[0x10]=0xDEADBEEF; pulse i_req with i_addr=0x10 -> i_gnt same cycle, ram_EN=1, ram_WE=0; next cycle i_rvalid=1, i_rdata=0xDEADBEEF, d_rvalid=0.
- Byte write then read: mem[0x20]=0x11223344; D write d_we=4'b0101, d_wdata=0xAABBCCDD -> d_rvalid next cycle with d_rdata=0x11223344. Then D read of 0x20 -> d_rdata=0x11BB33DD.
- Contention: i_req and d_req held high for 6 cycles after reset -> grants I,D,I,D,I,D; rvalid pulses alternate one cycle later; conflict_cnt=6.
- Back-to-back single port: d_req high 4 cycles, addresses 0..3 -> 4 consecutive d_rvalid pulses with the correct words; prio unchanged at 0.
- Reset mid-operation: grant I read, assert RSTn=0 in the next cycle before the clock edge -> i_rvalid=0 immediately and conflict_cnt=0. After release, a conflict goes to I first.
- Saturation: with CW=4, hold both requests 20 cycles -> conflict_cnt stops at 15.
